// File: rtl/axis_pkg.sv
// Shared definitions for the axis divider controller.
// Holds default widths, the Avalon register map addresses and the CTRL bit
// positions used by the controller and its testbench.
package axis_pkg;

  localparam int DIV_W_DEF  = 4;
  localparam int TCNT_W_DEF = 8;

  localparam logic [1:0] ADDR_DIV_REQ = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_TCNT    = 2'd3;

  localparam int CTRL_EN_BIT = 0;

endpackage

// File: rtl/axis_div_ctrl_if.sv
// Avalon-MM slave bus bundle for the axis divider controller.
// Signals: chipselect, address[1:0], write_n, read_n, writedata[7:0]
// (host to controller) and readdata[7:0] (controller to host).
interface axis_div_ctrl_if;

  logic       chipselect;
  logic [1:0] address;
  logic       write_n;
  logic       read_n;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport slave (
    input  chipselect,
    input  address,
    input  write_n,
    input  read_n,
    input  writedata,
    output readdata
  );

  modport master (
    output chipselect,
    output address,
    output write_n,
    output read_n,
    output writedata,
    input  readdata
  );

endinterface

// File: rtl/axis_prescaler.sv
// Prescaler for the axis rate tick.
// Ports: clk, reset (sync, active-high), enable_i (count while 1),
// active_div_i (exponent in force), tick_o (high on the terminal cycle).
// The counter is 2^DIV_W-1 bits wide so exponent 2^DIV_W-1 fits one period.
module axis_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] active_div_i,
  output logic             tick_o
);

  localparam int CNT_W = (1 << DIV_W) - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] term;

  always_comb begin
    // For the largest exponent the shift wraps to 0 and the subtract gives all ones.
    term   = (CNT_W'(1) << active_div_i) - CNT_W'(1);
    tick_o = enable_i && (cnt_q == term);
    cnt_d  = cnt_q + CNT_W'(1);
    // Disabling abandons the partial period; the terminal cycle restarts it.
    if (!enable_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_div_ctrl.sv
// Axis divider configuration controller and step-rate scheduler.
// Ports: clk, reset (sync, active-high), avs (Avalon-MM slave bundle),
// tick (rate pulse at clk/2^active_div), active_div (exponent in force),
// div_pending (request waiting for a period boundary),
// div_update (one-cycle pulse on the cycle a request is applied).
// Registers: 0 DIV_REQ, 1 CTRL (bit0 enable), 2 STATUS (RO), 3 TCNT.
module axis_div_ctrl
  import axis_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = 0,
  parameter int TCNT_W    = TCNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  axis_div_ctrl_if.slave   avs,
  output logic             tick,
  output logic [DIV_W-1:0] active_div,
  output logic             div_pending,
  output logic             div_update
);

  logic [DIV_W-1:0]  active_div_q, active_div_d;
  logic [DIV_W-1:0]  req_div_q, req_div_d;
  logic              pending_q, pending_d;
  logic              enable_q, enable_d;
  logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        readdata_q, readdata_d;
  logic              wr_en, rd_en, apply_w, tick_w;
  logic              unused_wdata;

  axis_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable_q),
    .active_div_i (active_div_q),
    .tick_o       (tick_w)
  );

  assign unused_wdata = ^avs.writedata;

  always_comb begin
    wr_en = avs.chipselect & ~avs.write_n;
    rd_en = avs.chipselect & ~avs.read_n;
    // Enabled: apply only on the terminal cycle so the count is already 0.
    // Disabled: the count is held at 0, so apply right away.
    apply_w = pending_q & (~enable_q | tick_w);

    active_div_d = active_div_q;
    req_div_d    = req_div_q;
    pending_d    = pending_q;
    enable_d     = enable_q;
    tick_cnt_d   = tick_cnt_q;
    readdata_d   = readdata_q;

    if (apply_w) begin
      active_div_d = req_div_q;
      pending_d    = 1'b0;
    end

    if (tick_w) begin
      tick_cnt_d = tick_cnt_q + TCNT_W'(1);
    end

    // Writes come after the apply so a colliding DIV_REQ write keeps pending set.
    if (wr_en) begin
      case (avs.address)
        ADDR_DIV_REQ: begin
          req_div_d = avs.writedata[DIV_W-1:0];
          pending_d = 1'b1;
        end
        ADDR_CTRL: enable_d   = avs.writedata[CTRL_EN_BIT];
        ADDR_TCNT: tick_cnt_d = '0;
        default:   ;
      endcase
    end

    // Reads use the current (pre-write) register values.
    if (rd_en) begin
      case (avs.address)
        ADDR_DIV_REQ: readdata_d = 8'(req_div_q);
        ADDR_CTRL:    readdata_d = 8'(enable_q);
        ADDR_STATUS:  readdata_d = 8'({active_div_q, 3'b000, pending_q});
        default:      readdata_d = 8'(tick_cnt_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_div_q <= DIV_W'(RESET_DIV);
      req_div_q    <= DIV_W'(RESET_DIV);
      pending_q    <= 1'b0;
      enable_q     <= 1'b0;
      tick_cnt_q   <= '0;
      readdata_q   <= '0;
    end else begin
      active_div_q <= active_div_d;
      req_div_q    <= req_div_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      tick_cnt_q   <= tick_cnt_d;
      readdata_q   <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign tick         = tick_w;
  assign active_div   = active_div_q;
  assign div_pending  = pending_q;
  assign div_update   = apply_w;

endmodule

// File: tb/tb_axis_div_ctrl.sv
module tb_axis_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] active_div;
  logic       div_pending;
  logic       div_update;

  axis_div_ctrl_if bus();

  axis_div_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .avs         (bus),
    .tick        (tick),
    .active_div  (active_div),
    .div_pending (div_pending),
    .div_update  (div_update)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: register values and the position inside the current period.
  int m_act, m_req, m_pend, m_en, m_pos, m_tcnt, m_rd;
  bit m_init = 0;

  function automatic int m_tick_f();
    return (m_en != 0 && m_pos == (2 ** m_act) - 1) ? 1 : 0;
  endfunction

  function automatic int m_upd_f();
    return (m_pend != 0 && (m_en == 0 || m_tick_f() != 0)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_req = 0; m_pend = 0; m_en = 0; m_pos = 0; m_tcnt = 0; m_rd = 0;
      m_init = 1;
    end else if (m_init) begin
      int tk, up, wr, rd, adr, wd;
      tk  = m_tick_f();
      up  = m_upd_f();
      wr  = (bus.chipselect && !bus.write_n) ? 1 : 0;
      rd  = (bus.chipselect && !bus.read_n) ? 1 : 0;
      adr = int'(bus.address);
      wd  = int'(bus.writedata);
      if (rd != 0) begin
        case (adr)
          0: m_rd = m_req;
          1: m_rd = m_en;
          2: m_rd = m_act * 16 + m_pend;
          default: m_rd = m_tcnt;
        endcase
      end
      m_pos = (m_en == 0 || tk != 0) ? 0 : m_pos + 1;
      if (tk != 0) m_tcnt = (m_tcnt + 1) % 256;
      if (up != 0) begin
        m_act  = m_req;
        m_pend = 0;
      end
      if (wr != 0) begin
        if (adr == 0) begin m_req = wd % 16; m_pend = 1; end
        if (adr == 1) m_en = wd % 2;
        if (adr == 3) m_tcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_tick", tick, m_tick_f());
      check("model_div_update", div_update, m_upd_f());
      check("model_active_div", active_div, m_act);
      check("model_div_pending", div_pending, m_pend);
      check("model_readdata", bus.readdata, m_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    cyc();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
    cyc();
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    d = bus.readdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int n;
    reset = 1'b1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    bus.address = 2'd0; bus.writedata = 8'd0;
    repeat (3) cyc();
    check("rst_tick", tick, 0);
    check("rst_active_div", active_div, 0);
    check("rst_pending", div_pending, 0);
    check("rst_update", div_update, 0);
    check("rst_readdata", bus.readdata, 0);
    reset = 1'b0;

    // Default exponent 0: tick every enabled cycle.
    wr(2'd1, 8'h01);
    check("div0_tick", tick, 1);
    repeat (9) cyc();
    wr(2'd1, 8'h00);
    rd(2'd3, r);
    check("div0_tcnt10", r, 10);
    wr(2'd3, 8'h00);

    // Request 3 while running at 0.
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h03);
    check("req3_update", div_update, 1);
    check("req3_pending", div_pending, 1);
    cyc();
    check("req3_active", active_div, 3);
    check("req3_pend_clr", div_pending, 0);
    for (int i = 0; i < 7; i++) begin
      check("div3_gap", tick, 0);
      cyc();
    end
    check("div3_tick", tick, 1);
    rd(2'd2, r);
    check("status_0x30", r, 8'h30);

    // Exponent 4, then two requests inside one period.
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h04);
    check("dis_update_now", div_update, 1);
    cyc();
    check("div4_active", active_div, 4);
    wr(2'd1, 8'h01);
    repeat (5) cyc();
    wr(2'd0, 8'h02);
    repeat (3) cyc();
    wr(2'd0, 8'h01);
    check("lastwins_no_early", div_update, 0);
    repeat (5) cyc();
    check("lastwins_update", div_update, 1);
    check("lastwins_tick", tick, 1);
    cyc();
    check("lastwins_active", active_div, 1);
    check("div1_t0", tick, 0);
    cyc();
    check("div1_t1", tick, 1);
    cyc();
    check("div1_t2", tick, 0);
    cyc();
    check("div1_t3", tick, 1);

    // Exponent 15 applied while disabled, then full period.
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h0F);
    check("div15_update", div_update, 1);
    check("div15_no_tick", tick, 0);
    cyc();
    check("div15_active", active_div, 15);
    wr(2'd1, 8'h01);
    n = 0;
    while (tick !== 1'b1 && n < 40000) begin
      cyc();
      n++;
    end
    check("div15_period", n + 1, 32768);

    // Tick counter wrap and clear-wins.
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h00);
    cyc();
    wr(2'd3, 8'h00);
    wr(2'd1, 8'h01);
    repeat (254) cyc();
    wr(2'd1, 8'h00);
    rd(2'd3, r);
    check("tcnt_255", r, 255);
    wr(2'd1, 8'h01);
    wr(2'd1, 8'h00);
    rd(2'd3, r);
    check("tcnt_wrap", r, 0);
    wr(2'd1, 8'h01);
    wr(2'd3, 8'h00);
    rd(2'd3, r);
    check("tcnt_clear_wins", r, 0);
    wr(2'd1, 8'h00);

    // Reset in the middle of a period with a request pending.
    wr(2'd0, 8'h02);
    cyc();
    wr(2'd1, 8'h01);
    wr(2'd0, 8'h05);
    rd(2'd2, r);
    check("pre_rst_status", r, 8'h21);
    check("pre_rst_no_update", div_update, 0);
    reset = 1'b1;
    cyc();
    check("mid_rst_active", active_div, 0);
    check("mid_rst_pending", div_pending, 0);
    check("mid_rst_update", div_update, 0);
    check("mid_rst_readdata", bus.readdata, 0);
    reset = 1'b0;
    rd(2'd3, r);
    check("post_rst_tcnt", r, 0);
    rd(2'd2, r);
    check("post_rst_status", r, 0);
    cyc();
    check("post_rst_no_update", div_update, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
